// File: rtl/branch_pkg.sv
// Shared encodings for the branch resolution path: branch-op codes,
// redirect FSM states and the default PC width.
package branch_pkg;

    localparam int PC_W_DEF    = 32;
    localparam int BR_OP_W_DEF = 3;

    // Branch-op encodings; 7 is reserved and behaves like NONE.
    localparam logic [2:0] BR_NONE = 3'd0;
    localparam logic [2:0] BR_BEQ  = 3'd1;
    localparam logic [2:0] BR_BNE  = 3'd2;
    localparam logic [2:0] BR_BLEZ = 3'd3;
    localparam logic [2:0] BR_BGTZ = 3'd4;
    localparam logic [2:0] BR_BLTZ = 3'd5;
    localparam logic [2:0] BR_BGEZ = 3'd6;

    // Redirect FSM: IDLE resolves branches, REDIR holds a redirect for fetch.
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_REDIR = 1'b1
    } br_state_t;

endpackage

// File: rtl/branch_cmp.sv
// Branch condition evaluator: BEQ/BNE compare rs and rt bitwise,
// the zero-compare ops look at rs as a signed value.
module branch_cmp
    import branch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int BR_OP_W = BR_OP_W_DEF
) (
    input  logic [BR_OP_W-1:0] i_br_op,
    input  logic [PC_W-1:0]    i_rs,
    input  logic [PC_W-1:0]    i_rt,
    output logic               o_cond
);

    logic w_eq;
    logic w_neg;
    logic w_zero;

    assign w_eq   = (i_rs == i_rt);
    assign w_neg  = i_rs[PC_W-1];
    assign w_zero = (i_rs == '0);

    // Select the condition for the current op; NONE/reserved give 0.
    always_comb begin
        o_cond = 1'b0;
        case (i_br_op)
            BR_OP_W'(BR_BEQ):  o_cond = w_eq;
            BR_OP_W'(BR_BNE):  o_cond = ~w_eq;
            BR_OP_W'(BR_BLEZ): o_cond = w_neg | w_zero;
            BR_OP_W'(BR_BGTZ): o_cond = ~w_neg & ~w_zero;
            BR_OP_W'(BR_BLTZ): o_cond = w_neg;
            BR_OP_W'(BR_BGEZ): o_cond = ~w_neg;
            default:           o_cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: evaluates the branch, flags mispredicts,
// holds a redirect PC until fetch takes it, and registers the M-stage
// predictor update record.
// Optional macro BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int BR_OP_W = BR_OP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               validE,
    input  logic [BR_OP_W-1:0] br_opE,
    input  logic [PC_W-1:0]    pcE,
    input  logic [PC_W-1:0]    rs_valE,
    input  logic [PC_W-1:0]    rt_valE,
    input  logic [PC_W-1:0]    immE,
    input  logic               pred_takeE,
    input  logic               stallE,
    input  logic               flushM,
    input  logic               redirect_ready,
    output logic               actual_takeE,
    output logic               preErrorE,
    output logic               flush_req,
    output logic               redirect_valid,
    output logic [PC_W-1:0]    redirect_pc,
    output logic               fetch_hold,
    output logic               branchM,
    output logic               actual_takeM,
    output logic [PC_W-1:0]    pcM
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]        stat_branches,
    output logic [31:0]        stat_mispredicts
`endif
);

    br_state_t       r_state;
    br_state_t       w_state_nxt;
    logic            w_isbr;
    logic            w_cond;
    logic [PC_W-1:0] w_seq_pc;
    logic [PC_W-1:0] w_tgt_pc;

    branch_cmp #(
        .PC_W    (PC_W),
        .BR_OP_W (BR_OP_W)
    ) u_cmp (
        .i_br_op (br_opE),
        .i_rs    (rs_valE),
        .i_rt    (rt_valE),
        .o_cond  (w_cond)
    );

    assign w_isbr = validE & (br_opE >= BR_OP_W'(BR_BEQ)) & (br_opE <= BR_OP_W'(BR_BGEZ));

    assign actual_takeE = w_isbr & w_cond;
    // Only checked in IDLE: during REDIR E holds the flushed bubble.
    assign preErrorE    = w_isbr & (actual_takeE != pred_takeE) & ~stallE & (r_state == ST_IDLE);
    assign flush_req    = preErrorE;

    // Offset is in words; additions wrap modulo 2^PC_W.
    assign w_seq_pc = pcE + PC_W'(4);
    assign w_tgt_pc = w_seq_pc + (immE << 2);

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // FSM next-state: enter REDIR on mispredict, leave on fetch handshake
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (preErrorE)      w_state_nxt = ST_REDIR;
            ST_REDIR: if (redirect_ready) w_state_nxt = ST_IDLE;
            default:                      w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: redirect is pending and PC frozen for all of REDIR
    always_comb begin
        redirect_valid = (r_state == ST_REDIR);
        fetch_hold     = (r_state == ST_REDIR);
    end

    // Capture the correct next PC at the mispredict; stable through REDIR
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            redirect_pc <= '0;
        else if (preErrorE) redirect_pc <= actual_takeE ? w_tgt_pc : w_seq_pc;
    end

    // M-stage update record: flush kills, stall inserts a bubble, else advance
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branchM      <= 1'b0;
            actual_takeM <= 1'b0;
            pcM          <= '0;
        end else if (flushM || stallE) begin
            branchM      <= 1'b0;
        end else begin
            branchM      <= w_isbr;
            actual_takeM <= actual_takeE;
            pcM          <= pcE;
        end
    end

`ifdef BRANCH_STATS_EN
    // Saturating counters of resolved branches and mispredicts
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else begin
            if (w_isbr && !stallE && stat_branches != 32'hFFFF_FFFF)
                stat_branches <= stat_branches + 32'd1;
            if (preErrorE && stat_mispredicts != 32'hFFFF_FFFF)
                stat_mispredicts <= stat_mispredicts + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus a
// randomized run against a cycle-level reference model.
module tb_branch_resolve;

    localparam int PC_W = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic            validE;
    logic [2:0]      br_opE;
    logic [PC_W-1:0] pcE, rs_valE, rt_valE, immE;
    logic            pred_takeE, stallE, flushM, redirect_ready;
    logic            actual_takeE, preErrorE, flush_req;
    logic            redirect_valid, fetch_hold;
    logic [PC_W-1:0] redirect_pc;
    logic            branchM, actual_takeM;
    logic [PC_W-1:0] pcM;
`ifdef BRANCH_STATS_EN
    logic [31:0]     stat_branches, stat_mispredicts;
`endif

    int errors = 0;
    int checks = 0;

    // Reference model state
    bit              m_redir;
    logic [PC_W-1:0] m_rpc;
    bit              m_brM, m_tkM;
    logic [PC_W-1:0] m_pcM;
    longint          m_nbr, m_nmis;

    always #5 clk = ~clk;

    branch_resolve #(.PC_W(PC_W), .BR_OP_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .validE         (validE),
        .br_opE         (br_opE),
        .pcE            (pcE),
        .rs_valE        (rs_valE),
        .rt_valE        (rt_valE),
        .immE           (immE),
        .pred_takeE     (pred_takeE),
        .stallE         (stallE),
        .flushM         (flushM),
        .redirect_ready (redirect_ready),
        .actual_takeE   (actual_takeE),
        .preErrorE      (preErrorE),
        .flush_req      (flush_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_hold     (fetch_hold),
        .branchM        (branchM),
        .actual_takeM   (actual_takeM),
        .pcM            (pcM)
`ifdef BRANCH_STATS_EN
        ,
        .stat_branches    (stat_branches),
        .stat_mispredicts (stat_mispredicts)
`endif
    );

    // Architectural branch rule from the op table.
    function automatic bit f_take(bit v, logic [2:0] op, logic [PC_W-1:0] rs, logic [PC_W-1:0] rt);
        int signed srs;
        srs = $signed(rs);
        if (!v) return 0;
        case (op)
            3'd1: return rs == rt;
            3'd2: return rs != rt;
            3'd3: return srs <= 0;
            3'd4: return srs > 0;
            3'd5: return srs < 0;
            3'd6: return srs >= 0;
            default: return 0;
        endcase
    endfunction

    function automatic bit f_isbr(bit v, logic [2:0] op);
        return v && op >= 3'd1 && op <= 3'd6;
    endfunction

    function automatic bit f_err();
        bit t;
        t = f_take(validE, br_opE, rs_valE, rt_valE);
        return f_isbr(validE, br_opE) && (t != pred_takeE) && !stallE && !m_redir;
    endfunction

    function automatic logic [PC_W-1:0] f_next_pc(bit take, logic [PC_W-1:0] pc, logic [PC_W-1:0] imm);
        longint unsigned s;
        s = longint'(pc) + 4 + (take ? (longint'($signed(imm)) * 4) : 0);
        return s[PC_W-1:0];
    endfunction

    task automatic model_reset();
        m_redir = 0; m_rpc = '0; m_brM = 0; m_tkM = 0; m_pcM = '0;
        m_nbr = 0; m_nmis = 0;
    endtask

    task automatic drive(bit v, logic [2:0] op, logic [PC_W-1:0] pc, logic [PC_W-1:0] rs,
                         logic [PC_W-1:0] rt, logic [PC_W-1:0] imm, bit pred, bit stall,
                         bit flm, bit rdy);
        validE = v; br_opE = op; pcE = pc; rs_valE = rs; rt_valE = rt; immE = imm;
        pred_takeE = pred; stallE = stall; flushM = flm; redirect_ready = rdy;
    endtask

    task automatic bubble(bit rdy);
        drive(0, 3'd0, '0, '0, '0, '0, 0, 0, 0, rdy);
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic tick();
        bit isbr, take, err;
        isbr = f_isbr(validE, br_opE);
        take = f_take(validE, br_opE, rs_valE, rt_valE);
        err  = f_err();
        @(posedge clk);
        if (err) begin
            m_redir = 1; m_rpc = f_next_pc(take, pcE, immE);
        end else if (m_redir && redirect_ready) begin
            m_redir = 0;
        end
        if (flushM || stallE) m_brM = 0;
        else begin m_brM = isbr; m_tkM = take; m_pcM = pcE; end
        if (isbr && !stallE && m_nbr < 64'hFFFF_FFFF) m_nbr++;
        if (err && m_nmis < 64'hFFFF_FFFF) m_nmis++;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1; model_reset();
        @(negedge clk);
        rst = 0;
        #1;
    endtask

    task automatic test_reset();
        bubble(0);
        rst = 1;
        model_reset();
        #2;
        checks++;
        if ({redirect_valid, fetch_hold, branchM, actual_takeM} !== 4'b0 || redirect_pc !== '0 || pcM !== '0) begin
            errors++;
            $display("FAIL reset_state: rv=%b fh=%b brM=%b tkM=%b rpc=%h pcM=%h required all 0",
                     redirect_valid, fetch_hold, branchM, actual_takeM, redirect_pc, pcM);
        end
        @(negedge clk); rst = 0; #1;
    endtask

    task automatic test_beq_mispredict();
        drive(1, 3'd1, 32'h100, 32'd5, 32'd5, 32'd3, 0, 0, 0, 0);
        #1;
        checks++;
        if ({actual_takeE, preErrorE, flush_req} !== 3'b111) begin
            errors++;
            $display("FAIL beq_comb: take/err/flush=%b%b%b required 111", actual_takeE, preErrorE, flush_req);
        end
        tick();
        bubble(0);
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h110 || flush_req !== 1'b0) begin
            errors++;
            $display("FAIL beq_redirect: rv=%b rpc=%h flush=%b required 1 00000110 0", redirect_valid, redirect_pc, flush_req);
        end
        checks++;
        if (branchM !== 1'b1 || actual_takeM !== 1'b1 || pcM !== 32'h100) begin
            errors++;
            $display("FAIL beq_record: brM=%b tkM=%b pcM=%h required 1 1 00000100", branchM, actual_takeM, pcM);
        end
        redirect_ready = 1;
        tick();
        bubble(0);
        checks++;
        if (redirect_valid !== 1'b0 || branchM !== 1'b0) begin
            errors++;
            $display("FAIL beq_release: rv=%b brM=%b required 0 0", redirect_valid, branchM);
        end
    endtask

    task automatic test_bne_hold();
        drive(1, 3'd2, 32'h200, 32'd7, 32'd7, 32'd9, 1, 0, 0, 0);
        #1;
        checks++;
        if (actual_takeE !== 1'b0 || preErrorE !== 1'b1) begin
            errors++;
            $display("FAIL bne_comb: take=%b err=%b required 0 1", actual_takeE, preErrorE);
        end
        tick();
        bubble(0);
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (redirect_valid !== 1'b1 || fetch_hold !== 1'b1 || redirect_pc !== 32'h204) begin
                errors++;
                $display("FAIL bne_hold[%0d]: rv=%b fh=%b rpc=%h required 1 1 00000204", i, redirect_valid, fetch_hold, redirect_pc);
            end
            tick();
        end
        redirect_ready = 1;
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h204) begin
            errors++;
            $display("FAIL bne_ready_cycle: rv=%b rpc=%h required 1 00000204", redirect_valid, redirect_pc);
        end
        tick();
        bubble(0);
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || fetch_hold !== 1'b0) begin
            errors++;
            $display("FAIL bne_drop: rv=%b fh=%b required 0 0", redirect_valid, fetch_hold);
        end
    endtask

    task automatic test_bgez_correct();
        drive(1, 3'd6, 32'h300, 32'h8000_0000, 32'd0, 32'd4, 0, 0, 0, 0);
        #1;
        checks++;
        if (actual_takeE !== 1'b0 || preErrorE !== 1'b0 || flush_req !== 1'b0) begin
            errors++;
            $display("FAIL bgez_comb: take=%b err=%b flush=%b required 0 0 0", actual_takeE, preErrorE, flush_req);
        end
        tick();
        bubble(0);
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || branchM !== 1'b1 || actual_takeM !== 1'b0 || pcM !== 32'h300) begin
            errors++;
            $display("FAIL bgez_record: rv=%b brM=%b tkM=%b pcM=%h required 0 1 0 00000300", redirect_valid, branchM, actual_takeM, pcM);
        end
        // Aliased prediction on a non-branch must not flag an error.
        drive(1, 3'd0, 32'h304, 32'd1, 32'd1, 32'd0, 1, 0, 0, 0);
        #1;
        checks++;
        if (preErrorE !== 1'b0 || actual_takeE !== 1'b0) begin
            errors++;
            $display("FAIL alias_nonbranch: err=%b take=%b required 0 0", preErrorE, actual_takeE);
        end
        tick();
        bubble(0);
    endtask

    task automatic test_stall();
        drive(1, 3'd1, 32'h400, 32'd2, 32'd2, 32'd8, 0, 1, 0, 0);
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (preErrorE !== 1'b0 || flush_req !== 1'b0) begin
                errors++;
                $display("FAIL stall_noerr[%0d]: err=%b flush=%b required 0 0", i, preErrorE, flush_req);
            end
            tick();
            checks++;
            if (branchM !== 1'b0) begin
                errors++;
                $display("FAIL stall_bubble[%0d]: brM=%b required 0", i, branchM);
            end
        end
        stallE = 0;
        #1;
        checks++;
        if (preErrorE !== 1'b1) begin
            errors++;
            $display("FAIL stall_release_err: err=%b required 1", preErrorE);
        end
        tick();
        bubble(0);
        #1;
        checks++;
        if (branchM !== 1'b1 || pcM !== 32'h400 || redirect_pc !== 32'h424) begin
            errors++;
            $display("FAIL stall_record: brM=%b pcM=%h rpc=%h required 1 00000400 00000424", branchM, pcM, redirect_pc);
        end
        redirect_ready = 1;
        tick();
        bubble(0);
        checks++;
        if (branchM !== 1'b0) begin
            errors++;
            $display("FAIL stall_single: brM=%b required 0", branchM);
        end
    endtask

    task automatic test_reset_mid_redirect();
        drive(1, 3'd4, 32'h500, 32'd3, 32'd0, 32'd1, 0, 0, 0, 0);
        tick();
        bubble(0);
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || branchM !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_setup: rv=%b brM=%b required 1 1", redirect_valid, branchM);
        end
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (redirect_valid !== 1'b0 || branchM !== 1'b0 || redirect_pc !== '0 || fetch_hold !== 1'b0) begin
            errors++;
            $display("FAIL rst_async: rv=%b brM=%b rpc=%h fh=%b required 0 0 0 0", redirect_valid, branchM, redirect_pc, fetch_hold);
        end
        @(negedge clk); rst = 0; #1;
        // IDLE after release: a fresh mispredict must be detected.
        drive(1, 3'd5, 32'h600, 32'hFFFF_FFFF, 32'd0, 32'd2, 0, 0, 0, 0);
        #1;
        checks++;
        if (preErrorE !== 1'b1) begin
            errors++;
            $display("FAIL rst_idle: err=%b required 1", preErrorE);
        end
        tick();
        bubble(1);
        tick();
        bubble(0);
    endtask

    task automatic test_wrap_and_stats();
        do_reset();
        drive(1, 3'd1, 32'h0, 32'd9, 32'd9, 32'hFFFF_FFFF, 0, 0, 0, 0);
        tick();
        bubble(0);
        #1;
        checks++;
        if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0) begin
            errors++;
            $display("FAIL wrap_target: rv=%b rpc=%h required 1 00000000", redirect_valid, redirect_pc);
        end
`ifdef BRANCH_STATS_EN
        checks++;
        if (stat_branches !== 32'd1 || stat_mispredicts !== 32'd1) begin
            errors++;
            $display("FAIL stats_single: br=%0d mis=%0d required 1 1", stat_branches, stat_mispredicts);
        end
`endif
        redirect_ready = 1;
        tick();
        bubble(0);
    endtask

    task automatic test_flush();
        drive(1, 3'd1, 32'h700, 32'd1, 32'd1, 32'd0, 1, 0, 1, 0);
        tick();
        bubble(0);
        #1;
        checks++;
        if (branchM !== 1'b0 || pcM !== 32'h0) begin
            errors++;
            $display("FAIL flush_kill: brM=%b pcM=%h required 0 00000000", branchM, pcM);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [PC_W-1:0] rs, rt;
            int sel;
            sel = $urandom_range(0, 3);
            rs = (sel == 0) ? '0 : PC_W'($urandom);
            rt = (sel == 1) ? rs : PC_W'($urandom);
            drive($urandom_range(0, 7) != 0, 3'($urandom), PC_W'($urandom) & ~32'h3, rs, rt,
                  PC_W'($signed(16'($urandom))), $urandom_range(0, 1),
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0);
            #1;
            checks++;
            if (actual_takeE !== f_take(validE, br_opE, rs_valE, rt_valE) || preErrorE !== f_err() || flush_req !== f_err()) begin
                errors++;
                $display("FAIL rand_comb[%0d]: take=%b err=%b flush=%b required %b %b %b", n, actual_takeE, preErrorE, flush_req,
                         f_take(validE, br_opE, rs_valE, rt_valE), f_err(), f_err());
            end
            checks++;
            if (redirect_valid !== m_redir || fetch_hold !== m_redir || (m_redir && redirect_pc !== m_rpc)) begin
                errors++;
                $display("FAIL rand_redir[%0d]: rv=%b fh=%b rpc=%h required %b %b %h", n, redirect_valid, fetch_hold, redirect_pc, m_redir, m_redir, m_rpc);
            end
            checks++;
            if (branchM !== m_brM || actual_takeM !== m_tkM || pcM !== m_pcM) begin
                errors++;
                $display("FAIL rand_record[%0d]: brM=%b tkM=%b pcM=%h required %b %b %h", n, branchM, actual_takeM, pcM, m_brM, m_tkM, m_pcM);
            end
`ifdef BRANCH_STATS_EN
            checks++;
            if (stat_branches !== 32'(m_nbr) || stat_mispredicts !== 32'(m_nmis)) begin
                errors++;
                $display("FAIL rand_stats[%0d]: br=%0d mis=%0d required %0d %0d", n, stat_branches, stat_mispredicts, m_nbr, m_nmis);
            end
`endif
            tick();
        end
    endtask

    initial begin
        rst = 1;
        bubble(0);
        model_reset();
        #3;
        test_reset();
        test_beq_mispredict();
        test_bne_hold();
        test_bgez_correct();
        test_stall();
        test_reset_mid_redirect();
        test_wrap_and_stats();
        test_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
